div_layer_signed_iter: RTL



---
 rtl/div_layer_pkg.sv | 16 +
 rtl/div_layer_step.sv | 16 +
 rtl/div_layer_signed_iter.sv | 96 +++++++++
 3 files changed

// File: rtl/div_layer_pkg.sv
// div_layer_pkg: shared state encoding and arithmetic helpers for the iterative signed divider.
package div_layer_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] wide_t;
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
    function automatic wide_t cond_neg(input wide_t v, input logic n);
        return n ? -v : v;
    endfunction
    function automatic wide_t magnitude(input wide_t v);
        return cond_neg(v, v[MAXW-1]);
    endfunction
endpackage

// File: rtl/div_layer_step.sv
// div_layer_step: one restoring division step (shift in a dividend bit, trial-subtract |B|).
module div_layer_step #(
    parameter int width1 = 8
) (
    input  logic [width1:0] i_rem,
    input  logic            i_bit,
    input  logic [width1:0] i_div,
    output logic [width1:0] o_rem,
    output logic            o_q
);
    logic [width1:0] w_shift, w_diff;
    assign w_shift = {i_rem[width1-1:0], i_bit};
    assign o_q     = {i_rem, i_bit} >= {1'b0, i_div};
    assign w_diff  = w_shift - i_div;
    assign o_rem   = o_q ? w_diff : w_shift;
endmodule

// File: rtl/div_layer_signed_iter.sv
// div_layer_signed_iter: iterative truncating signed divider, one quotient bit per clock.
module div_layer_signed_iter import div_layer_pkg::*; #(
    parameter int width1 = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [width1-1:0] A,
    input  logic [width1-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [width1-1:0] quotient,
    output logic [width1-1:0] remainder,
    output logic              div_by_zero
);
    localparam int CW = cnt_width(width1);
    state_t            r_state, w_next;
    logic [width1-1:0] r_aq, r_quotient, r_remainder;
    logic [width1:0]   r_b_mag, r_rem, w_rem_nxt;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_q, r_neg_r, r_dbz, w_q_bit, w_accept, w_b_zero;

    assign in_ready    = r_state == S_IDLE;
    assign out_valid   = r_state == S_DONE;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign w_accept    = in_valid && in_ready;
    assign w_b_zero    = B == '0;

    div_layer_step #(.width1(width1)) u_step (
        .i_rem (r_rem),
        .i_bit (r_aq[width1-1]),
        .i_div (r_b_mag),
        .o_rem (w_rem_nxt),
        .o_q   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_b_zero ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_aq starts as |A| and is shifted left; quotient bits fill in from the LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aq        <= '0;
            r_b_mag     <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_aq    <= width1'(magnitude(MAXW'($signed(A))));
                    r_b_mag <= (width1+1)'(magnitude(MAXW'($signed(B))));
                    r_neg_r <= A[width1-1];
                    r_neg_q <= A[width1-1] ^ B[width1-1];
                    r_rem   <= '0;
                    r_cnt   <= CW'(width1 - 1);
                    r_dbz   <= w_b_zero;
                    if (w_b_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= A;
                    end
                end
                S_CALC: begin
                    r_aq  <= {r_aq[width1-2:0], w_q_bit};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_quotient  <= width1'(cond_neg(MAXW'(r_aq), r_neg_q));
                    r_remainder <= width1'(cond_neg(MAXW'(r_rem), r_neg_r));
                end
                default: ;
            endcase
        end
    end
endmodule
